// File: rtl/ssd_decimal_scanner_if.sv
// Bundle of data/control signals between a value source and the decimal
// seven-segment scanner; the scanner takes the slave side.
interface ssd_decimal_scanner_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 4
);
  logic [WIDTH-1:0]  value;
  logic              blank_lz;
  logic              freeze;
  logic [DIGITS-1:0] anode;
  logic [6:0]        ssdOut;
  logic              upd;

  modport master (
    output value, blank_lz, freeze,
    input  anode, ssdOut, upd
  );

  modport slave (
    input  value, blank_lz, freeze,
    output anode, ssdOut, upd
  );
endinterface

// File: rtl/ssd_decimal_scanner.sv
// Multiplexed N-digit decimal display driver: sequential shift-and-add-3
// binary-to-BCD conversion, leading-zero blanking, overflow dashes, freeze.
module ssd_decimal_scanner #(
  parameter int WIDTH        = 16,
  parameter int DIGITS       = 4,
  parameter int REFRESH_BITS = 19
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ssd_decimal_scanner_if.slave  bus
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] LIMIT = pow10(DIGITS);

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0000001;
      4'd1:    seg7 = 7'b1001111;
      4'd2:    seg7 = 7'b0010010;
      4'd3:    seg7 = 7'b0000110;
      4'd4:    seg7 = 7'b1001100;
      4'd5:    seg7 = 7'b0100100;
      4'd6:    seg7 = 7'b0100000;
      4'd7:    seg7 = 7'b0001111;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0000100;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  typedef enum logic [1:0] {S_CAPTURE, S_SHIFT, S_COMMIT} state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    shreg_q, shreg_d;
  logic [BW-1:0]       bcd_q, bcd_d, bcd_adj;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic [BW-1:0]       disp_q, disp_d;
  logic [DIGITS-1:0]   mask_q, mask_d, lz_mask;
  logic                disp_ovf_q, disp_ovf_d;
  logic                valid_q, valid_d;
  logic                upd_q, upd_d;
  logic [REFRESH_BITS-1:0] presc_q;
  logic [KW-1:0]       k_q;
  logic [DIGITS-1:0]   anode_q;
  logic [6:0]          ssd_q, ssd_d;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                  bcd_q[gi*4 +: 4] + 4'd3 : bcd_q[gi*4 +: 4];
    end
  endgenerate

  // A digit is blanked only if it and every more-significant digit are zero.
  always_comb begin
    logic all_zero;
    all_zero = 1'b1;
    lz_mask  = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero && (bcd_q[i*4 +: 4] == 4'd0);
      if (i > 0) lz_mask[i] = bus.blank_lz && all_zero;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_CAPTURE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    disp_d     = disp_q;
    mask_d     = mask_q;
    disp_ovf_d = disp_ovf_q;
    valid_d    = valid_q;
    upd_d      = 1'b0;
    case (state_q)
      S_CAPTURE: begin
        shreg_d = bus.value;
        bcd_d   = '0;
        cnt_d   = '0;
        ovf_d   = (64'(bus.value) >= LIMIT);
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        bcd_d   = {bcd_adj[BW-2:0], shreg_q[WIDTH-1]};
        shreg_d = shreg_q << 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        if (!bus.freeze) begin
          disp_d     = bcd_q;
          mask_d     = lz_mask;
          disp_ovf_d = ovf_q;
          valid_d    = 1'b1;
          upd_d      = 1'b1;
        end
        state_d = S_CAPTURE;
      end
      default: state_d = S_CAPTURE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q    <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      disp_q     <= '0;
      mask_q     <= '0;
      disp_ovf_q <= 1'b0;
      valid_q    <= 1'b0;
      upd_q      <= 1'b0;
    end else begin
      shreg_q    <= shreg_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      disp_q     <= disp_d;
      mask_q     <= mask_d;
      disp_ovf_q <= disp_ovf_d;
      valid_q    <= valid_d;
      upd_q      <= upd_d;
    end
  end

  always_comb begin
    ssd_d = 7'b1111111;
    if (valid_q) begin
      if (disp_ovf_q)       ssd_d = 7'b1111110;
      else if (!mask_q[k_q]) ssd_d = seg7(disp_q[{k_q, 2'b00} +: 4]);
    end
  end

  // Scan index wraps at DIGITS, so it is compared explicitly rather than overflowing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      k_q     <= '0;
      anode_q <= '1;
      ssd_q   <= 7'b1111111;
    end else begin
      presc_q <= presc_q + 1'b1;
      if (&presc_q) k_q <= (k_q == KW'(DIGITS - 1)) ? '0 : k_q + 1'b1;
      anode_q <= ~(DIGITS'(1) << k_q);
      ssd_q   <= ssd_d;
    end
  end

  assign bus.anode  = anode_q;
  assign bus.ssdOut = ssd_q;
  assign bus.upd    = upd_q;
endmodule
